vga_pixel_fetcher: RTL and testbench
====================================

// Module: vga_pixel_fetcher
// PURPOSE
//  Consumer side of the VGA memory-address interface: takes per-pixel mem select, tile/char addresses
//  and offsets, issues reads to the tile ROM and character ROM, composites character over board,
//  maps palette index to 24-bit RGB. Syncs and blank are delay-matched so o_vga_* drive the DAC directly.
//  Sits between the VGA address generator and the board VGA pins.
// PARAMETERS
//  PIX_W      4    palette index width of both ROMs (16-entry palette)
//  BLINK_IDX  4'd7 tile palette index that blinks (power pellet)
//  BLINK_BIT  4    frame-counter bit that gates blink (period 2*2^BLINK_BIT frames)
// PORTS
//  i_clk            in   1    pixel clock
//  i_rst_n          in   1    reset, asynchronous, active-low
//  i_mem_select     in   2    [0]=board valid, [1]=character overlaps pixel
//  i_address_map    in   5    tile index
//  i_address_char   in   8    character sprite part index
//  i_tile_offset    in   6    pixel within 8x8 tile
//  i_char_offset    in   6    pixel within 8x8 sprite part
//  i_hsync,i_vsync  in   1    active-low syncs from VGA controller, aligned with inputs above
//  i_blank_n        in   1    1 = visible pixel
//  o_tile_rom_addr  out  11   {i_address_map,i_tile_offset}
//  i_tile_rom_data  in   PIX_W  sync ROM data, valid 1 cycle after address
//  o_char_rom_addr  out  14   {i_address_char,i_char_offset}
//  i_char_rom_data  in   PIX_W  sync ROM data, valid 1 cycle after address
//  o_vga_r/g/b      out  8 each  pixel colour
//  o_vga_hsync,o_vga_vsync,o_vga_blank_n  out 1  delay-matched controls
// BEHAVIOUR
//  Reset: ROM addrs 0, RGB 0, o_vga_hsync=1, o_vga_vsync=1, o_vga_blank_n=0, pipeline valid flags 0,
//   frame counter 0. Reset mid-frame flushes all stages; first valid RGB 3 cycles after release.
//  S0 (cycle n): register ROM addresses, mem_select, sync, blank. ROMs sampled at n+1 edge.
//  S1 (n+1): ROM data arrives; compose: char_hit = sel_d[1] & char_data!=0 (index 0 = transparent).
//   idx = char_hit ? {1,char_data[PIX_W-2:0]}... no: idx = char_hit ? char_data : (sel_d[0] ? tile_data : 0);
//   src flag kept to choose palette bank (char bank / tile bank, 2x16 entries).
//   Blink: tile source & idx==BLINK_IDX & frame_cnt[BLINK_BIT] -> idx forced 0.
//  S2 (n+2): registered palette lookup -> o_vga_r/g/b; blank_n=0 forces RGB 0.
//  Total latency 3 edges input->RGB; hsync/vsync/blank_n delayed exactly 3 edges, identical path.
//  Frame counter: 8-bit, increments on falling edge of delayed vsync (detected on registered copy);
//   wraps 255->0.
//  mem_select=2'b00: output palette index 0 of tile bank (black) regardless of ROM data.
//  Back-to-back pixels every cycle; no stalls, no handshake; ROM read every cycle unconditionally.
//  Palette: 32x24-bit constant table, tile index 0 and char index 0 = 24'h000000.
// CONFIGURATION
//  VGA_DEBUG_GRID_EN defined: pixels with tile offset row or column == 0 (offset[5:3]==0 or [2:0]==0)
//   on board area and no char_hit are output as 24'h404040, same latency. Undefined: no grid logic.
// TESTING
//  Reset held, random inputs -> RGB 0, hsync=vsync=1, blank_n=0; release -> valid after 3 clocks.
//  sel=01, map=3, tile_off=9, ROM returns 5 -> o_tile_rom_addr=11'd201, RGB=tile palette[5] 3 edges later.
//  sel=11, char ROM returns 0, tile ROM 2 -> tile palette[2]; char ROM returns 9 -> char palette[9].
//  hsync/vsync/blank_n pulse patterns -> output copies identical, shifted by exactly 3 cycles.
//  16 vsync falls with idx=BLINK_IDX -> shown frames 0-15, black frames 16-31 (BLINK_BIT=4).
//  Assert rst_n low mid-line -> all outputs reset asynchronously, no stale pixel after release.

Source files
------------

// File: rtl/vga_pixel_fetcher.sv
// rtl/vga_pixel_fetcher.sv - tile/char ROM fetch, sprite-over-board compositing and palette lookup for the VGA DAC
// Optional feature macro: VGA_DEBUG_GRID_EN (grey 8x8 tile grid drawn over the board area)
module vga_pixel_fetcher #(
   parameter int unsigned      PIX_W     = 4,
   parameter logic [PIX_W-1:0] BLINK_IDX = PIX_W'(7),
   parameter int unsigned      BLINK_BIT = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [1:0]       i_mem_select,
   input  logic [4:0]       i_address_map,
   input  logic [7:0]       i_address_char,
   input  logic [5:0]       i_tile_offset,
   input  logic [5:0]       i_char_offset,
   input  logic             i_hsync,
   input  logic             i_vsync,
   input  logic             i_blank_n,
   output logic [10:0]      o_tile_rom_addr,
   input  logic [PIX_W-1:0] i_tile_rom_data,
   output logic [13:0]      o_char_rom_addr,
   input  logic [PIX_W-1:0] i_char_rom_data,
   output logic [7:0]       o_vga_r,
   output logic [7:0]       o_vga_g,
   output logic [7:0]       o_vga_b,
   output logic             o_vga_hsync,
   output logic             o_vga_vsync,
   output logic             o_vga_blank_n
);

   // Entries 0-15: tile bank, 16-31: character bank; index 0 of each bank is black.
   localparam logic [23:0] PALETTE [0:31] = '{
      24'h000000, 24'h2121DE, 24'hFFB8AE, 24'hFFB851,
      24'hFFFFFF, 24'h00FFFF, 24'hFFB8FF, 24'hFFCC99,
      24'hDEDEFF, 24'h47B8AE, 24'hFF0000, 24'h00FF00,
      24'h0000FF, 24'hFFFF00, 24'h808080, 24'hC0C0C0,
      24'h000000, 24'hFFFF00, 24'hFF0000, 24'hFFB8FF,
      24'h00FFFF, 24'hFFB851, 24'h2121DE, 24'hFFFFFF,
      24'hDEDEFF, 24'hFF8800, 24'h47B7FF, 24'h00A000,
      24'hA000A0, 24'h606060, 24'hB0B0B0, 24'hF0F0F0
   };

   logic [1:0]       sel_0, sel_1;
   logic             hs_0, hs_1, vs_0, vs_1, bl_0, bl_1;
   logic             vs_prev;
   logic [7:0]       frame_cnt;
   logic [23:0]      rgb;
   logic             char_hit;
   logic [PIX_W-1:0] idx;
   logic [23:0]      pix;
`ifdef VGA_DEBUG_GRID_EN
   logic [5:0]       off_0, off_1;
`endif

   // sel_1 lines up with the ROM data, which the ROMs return one edge after our address register.
   always_comb begin
      char_hit = sel_1[1] && (i_char_rom_data != '0);
      idx      = '0;
      if (char_hit)
         idx = i_char_rom_data;
      else if (sel_1[0])
         idx = i_tile_rom_data;
      if (!char_hit && idx == BLINK_IDX && frame_cnt[BLINK_BIT])
         idx = '0;
      pix = PALETTE[{char_hit, idx}];
`ifdef VGA_DEBUG_GRID_EN
      if (sel_1[0] && !char_hit && (off_1[5:3] == 3'd0 || off_1[2:0] == 3'd0))
         pix = 24'h404040;
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_tile_rom_addr <= '0;
         o_char_rom_addr <= '0;
         sel_0           <= '0;
         sel_1           <= '0;
         hs_0            <= 1'b1;
         hs_1            <= 1'b1;
         o_vga_hsync     <= 1'b1;
         vs_0            <= 1'b1;
         vs_1            <= 1'b1;
         o_vga_vsync     <= 1'b1;
         bl_0            <= 1'b0;
         bl_1            <= 1'b0;
         o_vga_blank_n   <= 1'b0;
         rgb             <= '0;
         vs_prev         <= 1'b1;
         frame_cnt       <= '0;
`ifdef VGA_DEBUG_GRID_EN
         off_0           <= '0;
         off_1           <= '0;
`endif
      end else begin
         o_tile_rom_addr <= {i_address_map, i_tile_offset};
         o_char_rom_addr <= {i_address_char, i_char_offset};
         sel_0           <= i_mem_select;
         sel_1           <= sel_0;
         hs_0            <= i_hsync;
         hs_1            <= hs_0;
         o_vga_hsync     <= hs_1;
         vs_0            <= i_vsync;
         vs_1            <= vs_0;
         o_vga_vsync     <= vs_1;
         bl_0            <= i_blank_n;
         bl_1            <= bl_0;
         o_vga_blank_n   <= bl_1;
         rgb             <= bl_1 ? pix : 24'h000000;
         vs_prev         <= o_vga_vsync;
         if (vs_prev && !o_vga_vsync)
            frame_cnt <= frame_cnt + 8'd1;
`ifdef VGA_DEBUG_GRID_EN
         off_0           <= i_tile_offset;
         off_1           <= off_0;
`endif
      end
   end

   assign o_vga_r = rgb[23:16];
   assign o_vga_g = rgb[15:8];
   assign o_vga_b = rgb[7:0];

endmodule

// File: tb/tb_vga_pixel_fetcher.sv
// tb/tb_vga_pixel_fetcher.sv - directed self-checking bench for vga_pixel_fetcher
module tb_vga_pixel_fetcher;

   localparam logic [23:0] TILE2 = 24'hFFB8AE;
   localparam logic [23:0] TILE5 = 24'h00FFFF;
   localparam logic [23:0] TILE7 = 24'hFFCC99;
   localparam logic [23:0] CHAR9 = 24'hFF8800;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  mem_select;
   logic [4:0]  address_map;
   logic [7:0]  address_char;
   logic [5:0]  tile_offset, char_offset;
   logic        hsync, vsync, blank_n;
   logic [10:0] tile_rom_addr;
   logic [3:0]  tile_rom_data;
   logic [13:0] char_rom_addr;
   logic [3:0]  char_rom_data;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        vga_hsync, vga_vsync, vga_blank_n;
   logic [23:0] rgb;

   logic [3:0]  tile_mem [0:2047];
   logic [3:0]  char_mem [0:16383];

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      tile_rom_data <= tile_mem[tile_rom_addr];
      char_rom_data <= char_mem[char_rom_addr];
   end

   assign rgb = {vga_r, vga_g, vga_b};

   vga_pixel_fetcher dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_mem_select    (mem_select),
      .i_address_map   (address_map),
      .i_address_char  (address_char),
      .i_tile_offset   (tile_offset),
      .i_char_offset   (char_offset),
      .i_hsync         (hsync),
      .i_vsync         (vsync),
      .i_blank_n       (blank_n),
      .o_tile_rom_addr (tile_rom_addr),
      .i_tile_rom_data (tile_rom_data),
      .o_char_rom_addr (char_rom_addr),
      .i_char_rom_data (char_rom_data),
      .o_vga_r         (vga_r),
      .o_vga_g         (vga_g),
      .o_vga_b         (vga_b),
      .o_vga_hsync     (vga_hsync),
      .o_vga_vsync     (vga_vsync),
      .o_vga_blank_n   (vga_blank_n)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pix(input logic [1:0] sel, input logic [4:0] map, input logic [5:0] toff,
                          input logic [7:0] chr, input logic [5:0] coff);
      mem_select   = sel;
      address_map  = map;
      tile_offset  = toff;
      address_char = chr;
      char_offset  = coff;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_pix(2'($urandom), 5'($urandom), 6'($urandom), 8'($urandom), 6'($urandom));
         hsync = 1'($urandom); vsync = 1'($urandom); blank_n = 1'($urandom);
         step();
      end
      checks++; if (rgb !== 24'h0) begin fails++; $display("FAIL reset_rgb: got %h expected %h", rgb, 24'h0); end
      checks++; if (vga_hsync !== 1'b1) begin fails++; $display("FAIL reset_hsync: got %b expected 1", vga_hsync); end
      checks++; if (vga_vsync !== 1'b1) begin fails++; $display("FAIL reset_vsync: got %b expected 1", vga_vsync); end
      checks++; if (vga_blank_n !== 1'b0) begin fails++; $display("FAIL reset_blank_n: got %b expected 0", vga_blank_n); end
      checks++; if (tile_rom_addr !== 11'd0) begin fails++; $display("FAIL reset_tile_addr: got %0d expected 0", tile_rom_addr); end
      checks++; if (char_rom_addr !== 14'd0) begin fails++; $display("FAIL reset_char_addr: got %0d expected 0", char_rom_addr); end
      rst_n = 1'b1;
      set_pix(2'b01, 5'd3, 6'd9, 8'd0, 6'd0);
      hsync = 1'b1; vsync = 1'b1; blank_n = 1'b1;
      step();
      checks++; if (rgb !== 24'h0) begin fails++; $display("FAIL release_edge1: got %h expected %h", rgb, 24'h0); end
      step();
      checks++; if (rgb !== 24'h0) begin fails++; $display("FAIL release_edge2: got %h expected %h", rgb, 24'h0); end
      step();
      checks++; if (rgb !== TILE5) begin fails++; $display("FAIL release_edge3: got %h expected %h", rgb, TILE5); end
   endtask

   task automatic test_tile();
      set_pix(2'b01, 5'd3, 6'd9, 8'd0, 6'd0);
      step();
      checks++; if (tile_rom_addr !== 11'd201) begin fails++; $display("FAIL tile_addr: got %0d expected 201", tile_rom_addr); end
      step(); step();
      checks++; if (rgb !== TILE5) begin fails++; $display("FAIL tile_rgb: got %h expected %h", rgb, TILE5); end
   endtask

   task automatic test_char();
      set_pix(2'b11, 5'd1, 6'd10, 8'd10, 6'd5);
      step();
      checks++; if (char_rom_addr !== 14'd645) begin fails++; $display("FAIL char_addr: got %0d expected 645", char_rom_addr); end
      step(); step();
      checks++; if (rgb !== TILE2) begin fails++; $display("FAIL char_transparent: got %h expected %h", rgb, TILE2); end
      set_pix(2'b11, 5'd1, 6'd10, 8'd10, 6'd6);
      step(); step(); step();
      checks++; if (rgb !== CHAR9) begin fails++; $display("FAIL char_opaque: got %h expected %h", rgb, CHAR9); end
   endtask

   task automatic test_select_blank();
      set_pix(2'b00, 5'd3, 6'd9, 8'd10, 6'd6);
      step(); step(); step();
      checks++; if (rgb !== 24'h0) begin fails++; $display("FAIL sel00_black: got %h expected %h", rgb, 24'h0); end
      set_pix(2'b10, 5'd3, 6'd9, 8'd10, 6'd5);
      step(); step(); step();
      checks++; if (rgb !== 24'h0) begin fails++; $display("FAIL sel10_transparent: got %h expected %h", rgb, 24'h0); end
      set_pix(2'b01, 5'd3, 6'd9, 8'd0, 6'd0);
      blank_n = 1'b0;
      step(); step(); step();
      checks++; if (rgb !== 24'h0) begin fails++; $display("FAIL blank_forces_black: got %h expected %h", rgb, 24'h0); end
      blank_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [1:0]  sel  [0:3];
      logic [4:0]  map  [0:3];
      logic [5:0]  toff [0:3];
      logic [5:0]  coff [0:3];
      logic [23:0] exp_rgb [0:3];
      sel[0] = 2'b01; map[0] = 5'd3; toff[0] = 6'd9;  coff[0] = 6'd0; exp_rgb[0] = TILE5;
      sel[1] = 2'b11; map[1] = 5'd3; toff[1] = 6'd9;  coff[1] = 6'd6; exp_rgb[1] = CHAR9;
      sel[2] = 2'b00; map[2] = 5'd3; toff[2] = 6'd9;  coff[2] = 6'd6; exp_rgb[2] = 24'h0;
      sel[3] = 2'b01; map[3] = 5'd1; toff[3] = 6'd10; coff[3] = 6'd0; exp_rgb[3] = TILE2;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) set_pix(sel[i], map[i], toff[i], 8'd10, coff[i]);
         else       set_pix(2'b00, 5'd0, 6'd9, 8'd0, 6'd0);
         step();
         if (i >= 2) begin
            checks++;
            if (rgb !== exp_rgb[i-2]) begin
               fails++; $display("FAIL back_to_back[%0d]: got %h expected %h", i-2, rgb, exp_rgb[i-2]);
            end
         end
      end
   endtask

   task automatic test_blink();
      logic [23:0] exp_rgb;
      set_pix(2'b01, 5'd2, 6'd9, 8'd0, 6'd0);
      for (int f = 0; f < 32; f++) begin
         step(); step(); step();
         exp_rgb = (f < 16) ? TILE7 : 24'h0;
         checks++;
         if (rgb !== exp_rgb) begin
            fails++; $display("FAIL blink_frame%0d: got %h expected %h", f, rgb, exp_rgb);
         end
         vsync = 1'b0;
         step(); step();
         vsync = 1'b1;
         for (int k = 0; k < 5; k++) step();
      end
   endtask

   task automatic test_sync_delay();
      logic [11:0] hs_pat, vs_pat, bl_pat;
      hs_pat = 12'b1011_0011_1010;
      vs_pat = 12'b1110_0110_1101;
      bl_pat = 12'b0110_1100_0111;
      set_pix(2'b00, 5'd0, 6'd9, 8'd0, 6'd0);
      for (int i = 0; i < 12; i++) begin
         hsync = hs_pat[i]; vsync = vs_pat[i]; blank_n = bl_pat[i];
         step();
         if (i >= 2) begin
            checks++; if (vga_hsync !== hs_pat[i-2]) begin fails++; $display("FAIL hsync_delay[%0d]: got %b expected %b", i, vga_hsync, hs_pat[i-2]); end
            checks++; if (vga_vsync !== vs_pat[i-2]) begin fails++; $display("FAIL vsync_delay[%0d]: got %b expected %b", i, vga_vsync, vs_pat[i-2]); end
            checks++; if (vga_blank_n !== bl_pat[i-2]) begin fails++; $display("FAIL blank_delay[%0d]: got %b expected %b", i, vga_blank_n, bl_pat[i-2]); end
         end
      end
      hsync = 1'b1; vsync = 1'b1; blank_n = 1'b1;
   endtask

   task automatic test_mid_reset();
      set_pix(2'b01, 5'd3, 6'd9, 8'd0, 6'd0);
      hsync = 1'b0; vsync = 1'b0; blank_n = 1'b1;
      for (int i = 0; i < 4; i++) step();
      checks++; if (rgb !== TILE5) begin fails++; $display("FAIL pre_reset_rgb: got %h expected %h", rgb, TILE5); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (rgb !== 24'h0) begin fails++; $display("FAIL async_reset_rgb: got %h expected %h", rgb, 24'h0); end
      checks++; if (vga_hsync !== 1'b1) begin fails++; $display("FAIL async_reset_hsync: got %b expected 1", vga_hsync); end
      checks++; if (vga_vsync !== 1'b1) begin fails++; $display("FAIL async_reset_vsync: got %b expected 1", vga_vsync); end
      checks++; if (vga_blank_n !== 1'b0) begin fails++; $display("FAIL async_reset_blank_n: got %b expected 0", vga_blank_n); end
      checks++; if (tile_rom_addr !== 11'd0) begin fails++; $display("FAIL async_reset_tile_addr: got %0d expected 0", tile_rom_addr); end
      step(); step();
      rst_n = 1'b1;
      set_pix(2'b00, 5'd3, 6'd9, 8'd0, 6'd0);
      hsync = 1'b1; vsync = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (rgb !== 24'h0) begin fails++; $display("FAIL stale_pixel[%0d]: got %h expected %h", i, rgb, 24'h0); end
      end
      set_pix(2'b01, 5'd3, 6'd9, 8'd0, 6'd0);
      step(); step(); step();
      checks++; if (rgb !== TILE5) begin fails++; $display("FAIL post_reset_rgb: got %h expected %h", rgb, TILE5); end
   endtask

   initial begin
      for (int i = 0; i < 2048; i++)  tile_mem[i] = 4'd0;
      for (int i = 0; i < 16384; i++) char_mem[i] = 4'd0;
      tile_mem[201] = 4'd5;
      tile_mem[74]  = 4'd2;
      tile_mem[137] = 4'd7;
      char_mem[645] = 4'd0;
      char_mem[646] = 4'd9;
      rst_n = 1'b0;
      set_pix(2'b00, 5'd0, 6'd0, 8'd0, 6'd0);
      hsync = 1'b1; vsync = 1'b1; blank_n = 1'b0;
      #1;
      test_reset();
      test_tile();
      test_char();
      test_select_blank();
      test_back_to_back();
      test_blink();
      test_sync_delay();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
